ir_transmitter: RTL and testbench
=================================

IR_TRANSMITTER -- requirements
Module: ir_transmitter

Interface
REQ-001 Parameter UNIT_CYCLES, default 16200, sets clock cycles per 0.6 ms SIRC time unit at 27 MHz.
REQ-002 Parameter CARRIER_PERIOD, default 675, sets clock cycles per 40 kHz carrier period.
REQ-003 Parameter FRAME_UNITS, default 75, sets frame length in units measured from start-burst onset (45 ms).
REQ-004 clock  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 transmit  input  1  level request from main FSM; frames repeat while high.
REQ-007 command  input  12  move command; [7:0] distance, [11:8] angle.
REQ-008 ir_out  output  1  modulated drive to IR LED.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 frame_done  output  1  one-cycle pulse at the end of each complete frame.
REQ-011 frames_sent  output  8  count of completed frames since reset, wraps 255->0.

Function
REQ-012 States SHALL be IDLE, START_BURST, START_GAP, BIT_MARK, BIT_SPACE, FRAME_GAP.
REQ-013 In IDLE with transmit=1 at edge k: latch command into shift register, clear unit/carrier/frame counters, enter START_BURST; busy=1 and ir_out=1 in the cycle after edge k.
REQ-014 START_BURST SHALL last 4 units, then START_GAP for 1 unit.
REQ-015 12 bits SHALL be sent LSB first; BIT_MARK lasts 2 units for 1, 1 unit for 0; each mark followed by BIT_SPACE of 1 unit.
REQ-016 After BIT_SPACE of bit 11, enter FRAME_GAP; remain until the frame unit counter reaches FRAME_UNITS (frame length independent of data, 29-41 units active).
REQ-017 On FRAME_GAP exit: pulse frame_done for one cycle, increment frames_sent; if transmit=1, relatch command and enter START_BURST on the same edge (no idle cycle); else enter IDLE.
REQ-018 ir_out SHALL equal mark AND carrier_high, where mark = (state is START_BURST or BIT_MARK), carrier_high = carrier counter < CARRIER_PERIOD/2 (integer division).
REQ-019 Carrier counter SHALL reset to 0 at every mark onset and wrap CARRIER_PERIOD-1 -> 0; ir_out=0 in all non-mark states.
REQ-020 Deasserting transmit mid-frame SHALL NOT abort the frame; the frame completes, then IDLE.
REQ-021 command changes mid-frame SHALL be ignored; only latched value is transmitted.
REQ-022 Unit counter SHALL count 0..UNIT_CYCLES-1 per unit; state durations exact to the clock cycle.
REQ-023 Counters SHALL be wide enough for default parameters without overflow (unit >=14 bits, frame unit >=7 bits).

Reset
REQ-024 reset SHALL have priority over all other inputs, including mid-frame.
REQ-025 After reset: state IDLE, ir_out=0, busy=0, frame_done=0, frames_sent=0, shift register and all counters 0.
REQ-026 If transmit=1 during reset, transmission SHALL start on the first edge after reset deasserts, per REQ-013.

Verification (UNIT_CYCLES=10, CARRIER_PERIOD=4, FRAME_UNITS=75)
REQ-027 transmit pulsed 1 cycle, command=12'h002 -> one frame: 40-cycle burst with ir_out 1,1,0,0 pattern, 10 low, marks 10/20/10x10 cycles per bits, frame_done after exactly 750 cycles, frames_sent=1, busy=0 next cycle.
REQ-028 transmit held high, command=12'hFFF for 3 frames -> back-to-back frames each 750 cycles, each bit mark 20 cycles, frames_sent=3, no IDLE cycle between frames.
REQ-029 command switched 12'h000->12'hABC mid-frame with transmit held -> current frame carries 12'h000, next frame carries 12'hABC.
REQ-030 reset asserted during bit 5 of a frame -> next cycle ir_out=0, busy=0, frames_sent=0, no frame_done pulse.
REQ-031 frames_sent at 255 plus one completed frame -> frames_sent=0, frame_done pulsed.
REQ-032 transmit dropped during START_GAP -> frame completes full 750 cycles, then IDLE, ir_out=0.

Source files
------------

// File: rtl/ir_transmitter_if.sv
// Request/status bundle between the main controller and the SIRC IR transmitter.
// The master drives the request; the slave is the transmitter.
`timescale 1ns/1ps

interface ir_transmitter_if;
    logic        transmit;
    logic [11:0] command;
    logic        ir_out;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frames_sent;

    modport master (
        output transmit,
        output command,
        input  ir_out,
        input  busy,
        input  frame_done,
        input  frames_sent
    );

    modport slave (
        input  transmit,
        input  command,
        output ir_out,
        output busy,
        output frame_done,
        output frames_sent
    );
endinterface

// File: rtl/ir_transmitter.sv
// SIRC-style 12-bit IR frame transmitter: start burst, LSB-first pulse-width bits,
// fixed-length frames and a carrier-modulated LED drive.
`timescale 1ns/1ps

module ir_transmitter #(
    parameter int unsigned UNIT_CYCLES    = 16200,
    parameter int unsigned CARRIER_PERIOD = 675,
    parameter int unsigned FRAME_UNITS    = 75
) (
    input logic          clock,
    input logic          reset,
    ir_transmitter_if.slave bus
);

    localparam int unsigned UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned CAR_W  = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
    localparam int unsigned FRM_W  = $clog2(FRAME_UNITS + 1);
    localparam int unsigned HALF   = CARRIER_PERIOD / 2;

    typedef enum logic [2:0] {
        IDLE,
        START_BURST,
        START_GAP,
        BIT_MARK,
        BIT_SPACE,
        FRAME_GAP
    } state_t;

    state_t             state_q,       state_d;
    logic [11:0]        shift_q,       shift_d;
    logic [3:0]         bit_idx_q,     bit_idx_d;
    logic [UNIT_W-1:0]  unit_cnt_q,    unit_cnt_d;
    logic [1:0]         st_units_q,    st_units_d;
    logic [FRM_W-1:0]   frame_units_q, frame_units_d;
    logic [CAR_W-1:0]   carrier_q,     carrier_d;
    logic               ir_out_q,      ir_out_d;
    logic               busy_q,        busy_d;
    logic               frame_done_q,  frame_done_d;
    logic [7:0]         frames_sent_q, frames_sent_d;

    logic unit_end;
    logic start_frame;
    logic mark_d;
    logic mark_onset;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        unit_cnt_d    = unit_cnt_q;
        st_units_d    = st_units_q;
        frame_units_d = frame_units_q;
        frames_sent_d = frames_sent_q;
        frame_done_d  = 1'b0;
        start_frame   = 1'b0;

        unit_end = (state_q != IDLE) && (unit_cnt_q == UNIT_W'(UNIT_CYCLES - 1));

        if (state_q != IDLE) begin
            unit_cnt_d = unit_end ? '0 : unit_cnt_q + 1'b1;
            if (unit_end) begin
                st_units_d    = st_units_q + 2'd1;
                frame_units_d = frame_units_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.transmit) start_frame = 1'b1;
            end
            START_BURST: begin
                if (unit_end && st_units_q == 2'd3) begin
                    state_d    = START_GAP;
                    st_units_d = '0;
                end
            end
            START_GAP: begin
                if (unit_end) begin
                    state_d    = BIT_MARK;
                    st_units_d = '0;
                end
            end
            BIT_MARK: begin
                // A one is a two-unit mark, a zero a one-unit mark.
                if (unit_end && st_units_q == (shift_q[0] ? 2'd1 : 2'd0)) begin
                    state_d    = BIT_SPACE;
                    st_units_d = '0;
                end
            end
            BIT_SPACE: begin
                if (unit_end) begin
                    st_units_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_idx_q == 4'd11) begin
                        state_d   = FRAME_GAP;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = BIT_MARK;
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            FRAME_GAP: begin
                if (unit_end && frame_units_q >= FRM_W'(FRAME_UNITS - 1)) begin
                    frame_done_d  = 1'b1;
                    frames_sent_d = frames_sent_q + 8'd1;
                    st_units_d    = '0;
                    frame_units_d = '0;
                    if (bus.transmit) start_frame = 1'b1;
                    else              state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d       = START_BURST;
            shift_d       = bus.command;
            bit_idx_d     = '0;
            unit_cnt_d    = '0;
            st_units_d    = '0;
            frame_units_d = '0;
        end

        // Carrier phase restarts at each mark onset so every mark begins high.
        mark_d     = (state_d == START_BURST) || (state_d == BIT_MARK);
        mark_onset = mark_d && (start_frame || state_d != state_q);
        if (!mark_d || mark_onset)                          carrier_d = '0;
        else if (carrier_q == CAR_W'(CARRIER_PERIOD - 1))   carrier_d = '0;
        else                                                carrier_d = carrier_q + 1'b1;

        ir_out_d = mark_d && (carrier_d < CAR_W'(HALF));
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            unit_cnt_q    <= '0;
            st_units_q    <= '0;
            frame_units_q <= '0;
            carrier_q     <= '0;
            ir_out_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            unit_cnt_q    <= unit_cnt_d;
            st_units_q    <= st_units_d;
            frame_units_q <= frame_units_d;
            carrier_q     <= carrier_d;
            ir_out_q      <= ir_out_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign bus.ir_out      = ir_out_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// Directed-plus-random bench for ir_transmitter: every output cycle of each frame is
// compared against a timeline model built from the frame format rules.
`timescale 1ns/1ps

module tb_ir_transmitter;

    localparam int unsigned U     = 10;
    localparam int unsigned CP    = 4;
    localparam int unsigned FU    = 75;
    localparam int          FRAME = U * FU;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    always #5 clk = ~clk;

    ir_transmitter_if bus ();
    ir_transmitter_if bus2 ();

    ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_PERIOD(CP), .FRAME_UNITS(FU)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Short-unit instance so the 8-bit frame counter can wrap in a modest run.
    ir_transmitter #(.UNIT_CYCLES(1), .CARRIER_PERIOD(2), .FRAME_UNITS(FU)) dut_wrap (
        .clock (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    int checks   = 0;
    int failures = 0;
    int sent     = 0;

    // Expected LED drive at cycle t of a frame (t=0 is the first burst cycle).
    function automatic bit model_ir(input logic [11:0] cmd, input int t, input int u, input int cp);
        int pos;
        int len;
        if (t < 4 * u) return (t % cp) < (cp / 2);
        pos = 5 * u;
        for (int i = 0; i < 12; i++) begin
            len = cmd[i] ? 2 * u : u;
            if (t >= pos && t < pos + len) return ((t - pos) % cp) < (cp / 2);
            pos += len + u;
        end
        return 1'b0;
    endfunction

    function automatic int bit_start(input logic [11:0] cmd, input int k, input int u);
        int pos;
        pos = 5 * u;
        for (int i = 0; i < k; i++) pos += (cmd[i] ? 2 * u : u) + u;
        return pos;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input logic [11:0] cmd, input int t, input bit fd_exp);
        chk($sformatf("ir_out t=%0d cmd=%03h", t, cmd), bus.ir_out, model_ir(cmd, t, U, CP));
        chk($sformatf("busy t=%0d", t), bus.busy, 1);
        chk($sformatf("frame_done t=%0d", t), bus.frame_done, fd_exp);
    endtask

    task automatic run_frame(input logic [11:0] cmd, input bit fd0, input int drop_at,
                             input int chg_at, input logic [11:0] chg_val);
        for (int t = 0; t < FRAME; t++) begin
            if (t == drop_at) bus.transmit = 1'b0;
            if (t == chg_at)  bus.command  = chg_val;
            check_cycle(cmd, t, (t == 0) && fd0);
            tick;
        end
        sent = (sent + 1) % 256;
        chk("frame_done_end", bus.frame_done, 1);
        chk("frames_sent", bus.frames_sent, sent);
        chk("busy_after_frame", bus.busy, bus.transmit);
        if (!bus.transmit) chk("ir_out_idle", bus.ir_out, 0);
    endtask

    initial begin
        logic [11:0] cmd;
        logic [11:0] cmd2;
        int bs;
        int cnt;

        rst = 1'b1;
        rst2 = 1'b1;
        bus.transmit = 1'b0;
        bus.command = '0;
        bus2.transmit = 1'b0;
        bus2.command = '0;
        repeat (3) tick;

        chk("rst_ir_out", bus.ir_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_frames_sent", bus.frames_sent, 0);
        rst = 1'b0;
        tick;
        chk("idle_busy", bus.busy, 0);

        // Single-cycle request, command 0x002.
        bus.command = 12'h002;
        bus.transmit = 1'b1;
        tick;
        run_frame(12'h002, 1'b0, 0, -1, 12'h000);
        tick;
        chk("idle_busy_after", bus.busy, 0);
        chk("idle_fd_after", bus.frame_done, 0);

        // Three back-to-back all-ones frames.
        bus.command = 12'hFFF;
        bus.transmit = 1'b1;
        tick;
        run_frame(12'hFFF, 1'b0, -1, -1, 12'h000);
        run_frame(12'hFFF, 1'b1, -1, -1, 12'h000);
        run_frame(12'hFFF, 1'b1, 700, -1, 12'h000);

        // Command changes mid-frame only affect the following frame.
        bus.command = 12'h000;
        bus.transmit = 1'b1;
        tick;
        run_frame(12'h000, 1'b0, -1, 300, 12'hABC);
        run_frame(12'hABC, 1'b1, 100, -1, 12'h000);

        // Random commands with random mid-frame drop and command churn.
        for (int n = 0; n < 3; n++) begin
            cmd = 12'($urandom);
            bus.command = cmd;
            bus.transmit = 1'b1;
            tick;
            run_frame(cmd, 1'b0, int'($urandom_range(0, FRAME - 1)),
                      int'($urandom_range(0, FRAME - 1)), 12'($urandom));
        end

        // Request withdrawn during the start gap.
        cmd = 12'($urandom);
        bus.command = cmd;
        bus.transmit = 1'b1;
        tick;
        run_frame(cmd, 1'b0, 45, -1, 12'h000);

        // Reset in the middle of bit 5, with the request still held.
        cmd = 12'($urandom);
        bus.command = cmd;
        bus.transmit = 1'b1;
        tick;
        bs = bit_start(cmd, 5, U);
        for (int t = 0; t < bs + 3; t++) begin
            check_cycle(cmd, t, 1'b0);
            tick;
        end
        rst = 1'b1;
        tick;
        chk("midrst_ir_out", bus.ir_out, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_frames_sent", bus.frames_sent, 0);
        chk("midrst_frame_done", bus.frame_done, 0);
        sent = 0;
        tick;
        chk("rst_held_busy", bus.busy, 0);
        cmd2 = 12'($urandom);
        bus.command = cmd2;
        rst = 1'b0;
        tick;
        run_frame(cmd2, 1'b0, 200, -1, 12'h000);

        // Frame counter wrap on the short-unit instance.
        bus2.command = 12'($urandom);
        bus2.transmit = 1'b1;
        rst2 = 1'b0;
        tick;
        for (int n = 0; n < 256; n++) begin
            cnt = 0;
            bus2.command = 12'($urandom);
            do begin
                tick;
                cnt++;
            end while (!bus2.frame_done && cnt < 200);
            chk($sformatf("wrap_period n=%0d", n), cnt, FU);
            chk($sformatf("wrap_count n=%0d", n), bus2.frames_sent, (n + 1) % 256);
            chk($sformatf("wrap_busy n=%0d", n), bus2.busy, 1);
        end
        chk("wrap_final_count", bus2.frames_sent, 0);
        chk("wrap_final_pulse", bus2.frame_done, 1);
        bus2.transmit = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
